frame_buffer_banked: RTL and testbench
======================================

# frame_buffer_banked

Parametrised double-buffered frame store for the HUB75 controller. Pixels are written linearly into the back buffer while the scan side reads CHANNELS scan rows in parallel from the front buffer. The buffers are swapped on request, but only at a frame boundary signalled by the scan side. A hardware clear fills the back buffer with a constant.

## Interface
- WIDTH, 64, pixels per row (power of two)
- HEIGHT, 32, rows per frame; HEIGHT/CHANNELS must be a power of two
- PIXEL_BITS, 16, bits per pixel
- CHANNELS, 2, rows read in parallel (2 = top/bottom halves)
- CLEAR_VALUE, 0, pixel value written by clear
- Derived: FRAME = WIDTH*HEIGHT; BANK_DEPTH = FRAME/CHANNELS; WA = clog2(FRAME); RA = clog2(BANK_DEPTH)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- write_addr  in  WA  linear pixel index, row-major
- write_data  in  PIXEL_BITS  pixel
- write_en  in  1  write strobe
- read_addr  in  RA  index within each channel's bank
- read_en  in  1  read strobe
- read_data  out  CHANNELS*PIXEL_BITS  channel c in bits [c*PIXEL_BITS +: PIXEL_BITS]
- read_valid  out  1  read_data valid this cycle
- frame_sync  in  1  scan side at frame boundary, swap permitted
- swap_req  in  1  request front/back exchange
- swap_pending  out  1  request latched, not yet executed
- swap_done  out  1  one-cycle pulse after swap
- front_buffer  out  1  index of the buffer being read
- clear_req  in  1  start clearing the back buffer
- busy  out  1  clear in progress

## Operation
- Storage: 2 buffers × CHANNELS banks × BANK_DEPTH words.
- Write bank = write_addr[WA-1:RA]; write offset = write_addr[RA-1:0]. Writes always target buffer ~front_buffer.
- A read returns, for each channel c, pixel c*BANK_DEPTH + read_addr from buffer front_buffer. With default parameters, channel 0 is row r and channel 1 is row r+16.
- Swap state: IDLE → PENDING on swap_req.
  - Swap executes on an edge where (swap_pending | swap_req) & frame_sync & !busy.
  - On that edge front_buffer toggles and swap_pending clears.
  - swap_req while PENDING has no effect (no double swap).
- Clear FSM: IDLE → CLEARING on clear_req while idle.
  - busy is high for exactly BANK_DEPTH cycles.
  - A counter 0..BANK_DEPTH-1 writes CLEAR_VALUE to the same offset in all CHANNELS banks of the back buffer each cycle.
  - Back to IDLE after the last offset.
- During CLEARING: write_en is ignored, clear_req is ignored, and swap is held off (stays pending).
- Reads are unaffected by clear.

## Timing
- Reset values: read_data=0, read_valid=0, swap_pending=0, swap_done=0, front_buffer=0, busy=0. Clear counter=0, FSMs IDLE.
- Reset mid-clear aborts the clear; partially cleared contents are left as-is.
- Memory contents are not reset.
- Read latency 1: read_en sampled at edge N; read_data/read_valid are presented after edge N. read_valid is high for one cycle per accepted read_en. read_data holds its value when read_en=0.
- Write takes effect at the sampling edge; data is readable after a swap.
- Swap edge (same cycle as read_en/write_en):
  - The read uses the pre-swap front buffer.
  - The write uses the pre-swap back buffer.
- swap_done is high for the cycle after the swap edge.
- swap_req with frame_sync in the same cycle (not busy) swaps on that edge; swap_pending never asserts.
- clear_req and swap_req together: the clear starts and the swap stays pending until busy falls.
- busy rises the cycle after clear_req and falls after BANK_DEPTH cycles. The first swap is possible on the edge where busy is low and frame_sync is high.
- No address wrap: write_addr is full range by construction; read_addr is RA bits, so all values are legal.

## Test plan
- Default params: write FRAME pixels with value=index; swap_req+frame_sync; read addr 0..1023 → read_data top=addr, bottom=addr+1024, read_valid one cycle after each read_en.
- Swap hold-off: swap_req with frame_sync=0 for 10 cycles → swap_pending=1, front_buffer=0; frame_sync pulse → front_buffer=1 next cycle, swap_done single pulse, swap_pending=0.
- Isolation: write 0xAAAA to addr 5 of the back buffer while reading addr 5 of the front (holds 0x1234) → reads 0x1234 until the swap, then 0xAAAA.
- Clear: clear_req, CLEAR_VALUE=0xF800 → busy high exactly 1024 cycles; writes during busy ignored; swap_req during busy executes only after busy falls and frame_sync; all 2048 pixels read back 0xF800.
- Reset mid-clear at cycle 100 → busy=0, swap_pending=0, front_buffer=0, read_valid=0 after the reset edge.
- Params WIDTH=32, HEIGHT=16, CHANNELS=4, PIXEL_BITS=24: index pattern → read_addr r gives r, r+128, r+256, r+384 across 4 lanes.

Source files
------------

// File: rtl/frame_buffer_banked.sv
// frame_buffer_banked
//   Double-buffered frame store for the HUB75 controller. Pixels are written
//   linearly into the back buffer while the scan side reads CHANNELS rows in
//   parallel from the front buffer. A swap request is latched and executed
//   only at a frame boundary. A hardware clear fills the back buffer with
//   CLEAR_VALUE, one offset across all banks per cycle.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   write_addr/data/en      linear pixel write into the back buffer
//   read_addr/en            per-bank read index (latency 1)
//   read_data/valid         CHANNELS lanes, lane c at [c*PIXEL_BITS +: PIXEL_BITS]
//   frame_sync              scan side at frame boundary, swap permitted
//   swap_req/pending/done   swap request, latched request, post-swap pulse
//   front_buffer            index of the buffer being read
//   clear_req, busy         start clear of back buffer, clear in progress
module frame_buffer_banked #(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 32,
    parameter int PIXEL_BITS = 16,
    parameter int CHANNELS   = 2,
    parameter logic [PIXEL_BITS-1:0] CLEAR_VALUE = '0,
    localparam int FRAME      = WIDTH * HEIGHT,
    localparam int BANK_DEPTH = FRAME / CHANNELS,
    localparam int WA         = $clog2(FRAME),
    localparam int RA         = $clog2(BANK_DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [WA-1:0]                  write_addr,
    input  logic [PIXEL_BITS-1:0]          write_data,
    input  logic                           write_en,
    input  logic [RA-1:0]                  read_addr,
    input  logic                           read_en,
    output logic [CHANNELS*PIXEL_BITS-1:0] read_data,
    output logic                           read_valid,
    input  logic                           frame_sync,
    input  logic                           swap_req,
    output logic                           swap_pending,
    output logic                           swap_done,
    output logic                           front_buffer,
    input  logic                           clear_req,
    output logic                           busy
);

    localparam int CB = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {CLR_IDLE, CLR_ACTIVE} clr_state_t;
    typedef enum logic {SW_IDLE, SW_PENDING} swap_state_t;

    clr_state_t  clr_state;
    swap_state_t swap_state;
    logic [RA-1:0] clear_cnt;

    logic          clearing;
    logic          clear_start;
    logic          do_swap;
    logic          back_buffer;
    logic [CB-1:0] write_bank;
    logic [RA-1:0] write_offset;

    assign clearing     = (clr_state == CLR_ACTIVE);
    assign clear_start  = (clr_state == CLR_IDLE) && clear_req;
    assign back_buffer  = ~front_buffer;
    assign write_bank   = CB'(write_addr >> RA);
    assign write_offset = write_addr[RA-1:0];

    // A clear starting on this edge also blocks the swap, so the buffer being
    // cleared is still the back buffer for the whole clear.
    assign do_swap = ((swap_state == SW_PENDING) || swap_req) && frame_sync
                     && !clearing && !clear_start;

    assign busy         = clearing;
    assign swap_pending = (swap_state == SW_PENDING);

    // Clear sequencer: one offset per cycle across all banks of the back buffer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clr_state <= CLR_IDLE;
            clear_cnt <= '0;
        end else begin
            case (clr_state)
                CLR_IDLE: begin
                    if (clear_req) begin
                        clr_state <= CLR_ACTIVE;
                        clear_cnt <= '0;
                    end
                end
                CLR_ACTIVE: begin
                    if (clear_cnt == RA'(BANK_DEPTH - 1)) begin
                        clr_state <= CLR_IDLE;
                        clear_cnt <= '0;
                    end else begin
                        clear_cnt <= clear_cnt + 1'b1;
                    end
                end
                default: clr_state <= CLR_IDLE;
            endcase
        end
    end

    // Swap control: request latched until frame boundary with no clear active.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            swap_state   <= SW_IDLE;
            front_buffer <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            swap_done <= do_swap;
            if (do_swap) begin
                front_buffer <= ~front_buffer;
                swap_state   <= SW_IDLE;
            end else if (swap_req) begin
                swap_state <= SW_PENDING;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) read_valid <= 1'b0;
        else          read_valid <= read_en;
    end

    // One memory per channel holding both buffers; the buffer index is the
    // address MSB. Write and read both use the pre-edge front_buffer, so a
    // swap edge reads the old front and writes the old back.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_bank
        logic [PIXEL_BITS-1:0] mem [2*BANK_DEPTH];
        logic                  bank_we;
        logic [RA:0]           bank_waddr;
        logic [PIXEL_BITS-1:0] bank_wdata;
        logic [PIXEL_BITS-1:0] lane_q;

        always_comb begin
            bank_we    = clearing || (write_en && (write_bank == CB'(c)));
            bank_waddr = {back_buffer, (clearing ? clear_cnt : write_offset)};
            bank_wdata = clearing ? CLEAR_VALUE : write_data;
        end

        always_ff @(posedge clk) begin
            if (bank_we) mem[bank_waddr] <= bank_wdata;
        end

        always_ff @(posedge clk) begin
            if (!reset_n)     lane_q <= '0;
            else if (read_en) lane_q <= mem[{front_buffer, read_addr}];
        end

        assign read_data[c*PIXEL_BITS +: PIXEL_BITS] = lane_q;
    end

endmodule

// File: tb/tb_frame_buffer_banked.sv
// Testbench for frame_buffer_banked: default-geometry instance with a
// non-zero clear value, plus a 4-channel 24-bit instance.
module tb_frame_buffer_banked;

    localparam int WA1 = 11;
    localparam int RA1 = 10;
    localparam int WA2 = 9;
    localparam int RA2 = 7;

    logic clk;
    int   checks = 0;
    int   errors = 0;
    bit   done1 = 0;
    bit   done2 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance (64x32, 2 ch, 16 bit) ----------------
    logic            reset_n;
    logic [WA1-1:0]  write_addr;
    logic [15:0]     write_data;
    logic            write_en;
    logic [RA1-1:0]  read_addr;
    logic            read_en;
    logic [31:0]     read_data;
    logic            read_valid;
    logic            frame_sync, swap_req, swap_pending, swap_done, front_buffer;
    logic            clear_req, busy;

    frame_buffer_banked #(
        .WIDTH(64), .HEIGHT(32), .PIXEL_BITS(16), .CHANNELS(2),
        .CLEAR_VALUE(16'hF800)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
        .read_addr(read_addr), .read_en(read_en),
        .read_data(read_data), .read_valid(read_valid),
        .frame_sync(frame_sync), .swap_req(swap_req),
        .swap_pending(swap_pending), .swap_done(swap_done),
        .front_buffer(front_buffer),
        .clear_req(clear_req), .busy(busy)
    );

    // ---------------- second instance (32x16, 4 ch, 24 bit) ----------------
    logic            reset_n2;
    logic [WA2-1:0]  write_addr2;
    logic [23:0]     write_data2;
    logic            write_en2;
    logic [RA2-1:0]  read_addr2;
    logic            read_en2;
    logic [95:0]     read_data2;
    logic            read_valid2;
    logic            frame_sync2, swap_req2, swap_pending2, swap_done2, front_buffer2;
    logic            clear_req2, busy2;

    frame_buffer_banked #(
        .WIDTH(32), .HEIGHT(16), .PIXEL_BITS(24), .CHANNELS(4)
    ) u_dut4 (
        .clk(clk), .reset_n(reset_n2),
        .write_addr(write_addr2), .write_data(write_data2), .write_en(write_en2),
        .read_addr(read_addr2), .read_en(read_en2),
        .read_data(read_data2), .read_valid(read_valid2),
        .frame_sync(frame_sync2), .swap_req(swap_req2),
        .swap_pending(swap_pending2), .swap_done(swap_done2),
        .front_buffer(front_buffer2),
        .clear_req(clear_req2), .busy(busy2)
    );

    // ---------------- scoreboards and monitors ----------------
    logic [31:0] exp_q1[$];
    logic [95:0] exp_q2[$];

    always @(negedge clk) begin
        if (read_valid === 1'b1) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL rd1_unexpected actual=%h required=no valid", read_data);
            end else begin
                logic [31:0] e;
                e = exp_q1.pop_front();
                if (read_data !== e) begin
                    errors++;
                    $display("FAIL rd1_data actual=%h required=%h", read_data, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (read_valid2 === 1'b1) begin
            checks++;
            if (exp_q2.size() == 0) begin
                errors++;
                $display("FAIL rd2_unexpected actual=%h required=no valid", read_data2);
            end else begin
                logic [95:0] e;
                e = exp_q2.pop_front();
                if (read_data2 !== e) begin
                    errors++;
                    $display("FAIL rd2_data actual=%h required=%h", read_data2, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Returns just after a rising edge; inputs set afterwards apply to the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input int a, input logic [15:0] d);
        write_en = 1'b1; write_addr = WA1'(a); write_data = d;
        tick();
        write_en = 1'b0;
    endtask

    task automatic rd1(input int a, input logic [31:0] e);
        read_en = 1'b1; read_addr = RA1'(a);
        exp_q1.push_back(e);
        tick();
        read_en = 1'b0;
    endtask

    task automatic swap1();
        swap_req = 1'b1; frame_sync = 1'b1;
        tick();
        swap_req = 1'b0; frame_sync = 1'b0;
    endtask

    // ---------------- main instance stimulus ----------------
    initial begin
        int busy_cycles;
        bit front_moved;
        reset_n = 1'b0; write_addr = '0; write_data = '0; write_en = 1'b0;
        read_addr = '0; read_en = 1'b0; frame_sync = 1'b0; swap_req = 1'b0;
        clear_req = 1'b0;
        repeat (3) tick();
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_read_valid", 32'(read_valid), 32'h0);
        chk("rst_swap_pending", 32'(swap_pending), 32'h0);
        chk("rst_swap_done", 32'(swap_done), 32'h0);
        chk("rst_front", 32'(front_buffer), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        tick();

        // Fill back buffer (1) with index pattern, swap with req+sync together.
        for (int i = 0; i < 2048; i++) wr1(i, 16'(i));
        swap1();
        chk("swap_front", 32'(front_buffer), 32'h1);
        chk("swap_done_pulse", 32'(swap_done), 32'h1);
        chk("swap_no_pending", 32'(swap_pending), 32'h0);
        tick();
        chk("swap_done_drop", 32'(swap_done), 32'h0);

        for (int a = 0; a < 1024; a++) rd1(a, {16'(a + 1024), 16'(a)});
        tick(); tick();
        chk("read_hold", read_data, 32'h07FF_03FF);
        chk("read_valid_low", 32'(read_valid), 32'h0);

        // Fill buffer 0 with index, mark addr 5, make it the front.
        for (int i = 0; i < 2048; i++) wr1(i, 16'(i));
        wr1(5, 16'h1234);
        swap1();
        chk("swap2_front", 32'(front_buffer), 32'h0);

        // Hold-off: request without frame_sync; writes to the back stay isolated.
        swap_req = 1'b1; frame_sync = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            swap_req = k[0];
            write_en = 1'b1; write_addr = 11'd5; write_data = 16'hAAAA;
            rd1(5, {16'd1029, 16'h1234});
        end
        swap_req = 1'b0; write_en = 1'b0;
        chk("holdoff_pending", 32'(swap_pending), 32'h1);
        chk("holdoff_front", 32'(front_buffer), 32'h0);
        chk("holdoff_no_done", 32'(swap_done), 32'h0);

        // Swap edge: read sees old front, write lands in old back.
        frame_sync = 1'b1;
        write_en = 1'b1; write_addr = 11'd6; write_data = 16'h5555;
        rd1(5, {16'd1029, 16'h1234});
        frame_sync = 1'b0; write_en = 1'b0;
        chk("holdoff_swap_front", 32'(front_buffer), 32'h1);
        chk("holdoff_swap_done", 32'(swap_done), 32'h1);
        chk("holdoff_pending_clr", 32'(swap_pending), 32'h0);
        rd1(5, {16'd1029, 16'hAAAA});
        chk("holdoff_done_single", 32'(swap_done), 32'h0);
        rd1(6, {16'd1030, 16'h5555});
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("no_double_swap", 32'(front_buffer), 32'h1);

        // Clear back buffer 0 with a simultaneous swap request and frame_sync.
        clear_req = 1'b1; swap_req = 1'b1; frame_sync = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("clr_busy_rise", 32'(busy), 32'h1);
        chk("clr_pending", 32'(swap_pending), 32'h1);
        chk("clr_front_held", 32'(front_buffer), 32'h1);
        busy_cycles = 1;
        front_moved = 0;
        for (int n = 0; n < 2000 && busy === 1'b1; n++) begin
            write_en = 1'b1;
            write_addr = n[0] ? 11'd2047 : 11'd3;
            write_data = 16'h7777;
            tick();
            if (busy === 1'b1) busy_cycles++;
            if (front_buffer !== 1'b1) front_moved = 1;
        end
        clear_req = 1'b0; write_en = 1'b0;
        chk("clr_busy_cycles", 32'(busy_cycles), 32'd1024);
        chk("clr_no_swap_while_busy", 32'(front_moved), 32'h0);
        chk("clr_pending_at_fall", 32'(swap_pending), 32'h1);
        tick();
        frame_sync = 1'b0;
        chk("clr_swap_front", 32'(front_buffer), 32'h0);
        chk("clr_swap_done", 32'(swap_done), 32'h1);
        chk("clr_swap_pending", 32'(swap_pending), 32'h0);
        for (int a = 0; a < 1024; a++) rd1(a, 32'hF800_F800);
        tick(); tick();

        // Reset part-way through a clear with a swap pending.
        swap1();
        chk("pre_rst_front", 32'(front_buffer), 32'h1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (49) tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("pre_rst_pending", 32'(swap_pending), 32'h1);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        repeat (48) tick();
        reset_n = 1'b0; read_en = 1'b1; read_addr = '0;
        tick();
        reset_n = 1'b1; read_en = 1'b0;
        chk("midclr_busy", 32'(busy), 32'h0);
        chk("midclr_pending", 32'(swap_pending), 32'h0);
        chk("midclr_front", 32'(front_buffer), 32'h0);
        chk("midclr_valid", 32'(read_valid), 32'h0);
        chk("midclr_data", read_data, 32'h0);
        repeat (3) tick();
        chk("midclr_stays_idle", 32'(busy), 32'h0);
        done1 = 1;
    end

    // ---------------- second instance stimulus ----------------
    initial begin
        reset_n2 = 1'b0; write_addr2 = '0; write_data2 = '0; write_en2 = 1'b0;
        read_addr2 = '0; read_en2 = 1'b0; frame_sync2 = 1'b0; swap_req2 = 1'b0;
        clear_req2 = 1'b0;
        repeat (3) tick();
        chk("rst2_read_data_lo", read_data2[31:0], 32'h0);
        chk("rst2_front", 32'(front_buffer2), 32'h0);
        reset_n2 = 1'b1;
        tick();
        for (int i = 0; i < 512; i++) begin
            write_en2 = 1'b1; write_addr2 = WA2'(i); write_data2 = 24'(i);
            tick();
        end
        write_en2 = 1'b0;
        swap_req2 = 1'b1; frame_sync2 = 1'b1;
        tick();
        swap_req2 = 1'b0; frame_sync2 = 1'b0;
        chk("swap4_front", 32'(front_buffer2), 32'h1);
        for (int r = 0; r < 128; r++) begin
            read_en2 = 1'b1; read_addr2 = RA2'(r);
            exp_q2.push_back({24'(r + 384), 24'(r + 256), 24'(r + 128), 24'(r)});
            tick();
        end
        read_en2 = 1'b0;
        tick(); tick();
        done2 = 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 20000 && !(done1 && done2); i++) @(posedge clk);
        chk("main_seq_done", 32'(done1), 32'h1);
        chk("ch4_seq_done", 32'(done2), 32'h1);
        repeat (2) @(posedge clk);
        chk("rd1_outstanding", 32'(exp_q1.size()), 32'h0);
        chk("rd2_outstanding", 32'(exp_q2.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
